// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, entry type and queue state encoding for the LCD byte path
package lcd_pkg;

  // dc flag values carried with every queued byte
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // PCD8544 command bytes used by the display sequencer
  localparam logic [7:0] FUNC_EXT    = 8'h21;
  localparam logic [7:0] VOP         = 8'h90;
  localparam logic [7:0] FUNC_BASIC  = 8'h20;
  localparam logic [7:0] DISP_NORMAL = 8'h0C;
  localparam logic [7:0] SET_X       = 8'h80;
  localparam logic [7:0] SET_Y       = 8'h40;
  localparam int         SCREEN_BYTES = 504;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } q_state_e;

  // one queue entry: dc flag above the byte
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } lcd_entry_t;

endpackage

// File: rtl/lcd_byte_queue_if.sv
// rtl/lcd_byte_queue_if.sv - sequencer-side and SPI-master-side signals of the LCD byte queue
interface lcd_byte_queue_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int FILL_W     = 10
);
  logic                  wr_en;
  logic                  wr_dc;
  logic [7:0]            wr_data;
  logic                  fill_start;
  logic                  fill_dc;
  logic [7:0]            fill_data;
  logic [FILL_W-1:0]     fill_len;
  logic                  full;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  fill_busy;
  logic                  idle;
  logic                  busy;
  logic                  avail;
  logic [7:0]            message;
  logic                  comm;
  logic                  spistart;

  // the environment: sequencer pushes/fills, SPI master reports busy/avail
  modport master (
    output wr_en, wr_dc, wr_data, fill_start, fill_dc, fill_data, fill_len, busy, avail,
    input  full, level, overflow, fill_busy, idle, message, comm, spistart
  );

  // the queue itself
  modport slave (
    input  wr_en, wr_dc, wr_data, fill_start, fill_dc, fill_data, fill_len, busy, avail,
    output full, level, overflow, fill_busy, idle, message, comm, spistart
  );
endinterface

// File: rtl/lcd_sync_fifo.sv
// rtl/lcd_sync_fifo.sv - 9-bit synchronous FIFO with level and a look-ahead head output
module lcd_sync_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic                pop_i,
  input  lcd_entry_t          wdata_i,
  output lcd_entry_t          next_head_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic                full_o,
  output logic                empty_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  lcd_entry_t                mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]     wr_ptr_q, rd_ptr_q, rd_next;
  logic [DEPTH_LOG2:0]       cnt_q, cnt_after_pop;
  logic                      do_push, do_pop;

  assign full_o  = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  // a push into a full FIFO is refused even when a pop happens in the same cycle
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // head as it will be after this cycle's pop/push, so the caller can register it
  always_comb begin
    rd_next       = rd_ptr_q + DEPTH_LOG2'(do_pop);
    cnt_after_pop = cnt_q - (DEPTH_LOG2+1)'(do_pop);
    next_head_o   = (cnt_after_pop == '0) ? wdata_i : mem_q[rd_next];
  end

  // storage write, no reset needed on the array
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // pointers and occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (DEPTH_LOG2+1)'(1);
        2'b01:   cnt_q <= cnt_q - (DEPTH_LOG2+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/lcd_byte_queue.sv
// rtl/lcd_byte_queue.sv - elastic {dc,byte} queue with fill engine feeding the PCD8544 SPI master
module lcd_byte_queue
  import lcd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int FILL_W     = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  lcd_byte_queue_if.slave   bus
);
  q_state_e            state_q, state_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic                fill_busy_q, fill_busy_d;
  lcd_entry_t          fill_ent_q, fill_ent_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          message_q, message_d;
  logic                comm_q, comm_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  lcd_entry_t          fifo_wdata, fifo_next_head;
  logic [DEPTH_LOG2:0] fifo_level;

  lcd_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .wdata_i     (fifo_wdata),
    .next_head_o (fifo_next_head),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // write-side arbitration: fill engine owns the FIFO input while busy, else sequencer pushes
  always_comb begin
    fill_cnt_d  = fill_cnt_q;
    fill_busy_d = fill_busy_q;
    fill_ent_d  = fill_ent_q;
    overflow_d  = overflow_q;
    fifo_push   = 1'b0;
    fifo_wdata  = '{dc: bus.wr_dc, data: bus.wr_data};
    if (fill_busy_q) begin
      fifo_wdata = fill_ent_q;
      if (!fifo_full) begin
        fifo_push   = 1'b1;
        fill_cnt_d  = fill_cnt_q - FILL_W'(1);
        fill_busy_d = (fill_cnt_q != FILL_W'(1));
      end
    end else begin
      fifo_push = bus.wr_en && !fifo_full;
      if (bus.fill_start && (bus.fill_len != '0)) begin
        fill_cnt_d  = bus.fill_len;
        fill_busy_d = 1'b1;
        fill_ent_d  = '{dc: bus.fill_dc, data: bus.fill_data};
      end
    end
    if (bus.wr_en && (fifo_full || fill_busy_q)) overflow_d = 1'b1;
  end

  // queue FSM: stream while entries exist, then wait out the last SPI byte before idling
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty || fifo_push) state_d = STREAM;
      end
      STREAM: begin
        if (bus.avail && !fifo_empty) begin
          fifo_pop = 1'b1;
          if ((fifo_level == (DEPTH_LOG2+1)'(1)) && !fifo_push) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // load the post-update head whenever the next cycle streams, giving one-cycle push latency
  always_comb begin
    message_d = message_q;
    comm_d    = comm_q;
    if (state_d == STREAM) begin
      message_d = fifo_next_head.data;
      comm_d    = fifo_next_head.dc;
    end
  end

  // state, fill engine and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      fill_busy_q <= 1'b0;
      fill_ent_q  <= '0;
      overflow_q  <= 1'b0;
      message_q   <= 8'h00;
      comm_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_busy_q <= fill_busy_d;
      fill_ent_q  <= fill_ent_d;
      overflow_q  <= overflow_d;
      message_q   <= message_d;
      comm_q      <= comm_d;
    end
  end

  assign bus.message   = message_q;
  assign bus.comm      = comm_q;
  assign bus.spistart  = (state_q == STREAM);
  assign bus.full      = fifo_full || fill_busy_q;
  assign bus.level     = fifo_level;
  assign bus.overflow  = overflow_q;
  assign bus.fill_busy = fill_busy_q;
  assign bus.idle      = (state_q == IDLE) && fifo_empty && !fill_busy_q && !bus.busy;
endmodule

// File: tb/tb_lcd_byte_queue.sv
// tb/tb_lcd_byte_queue.sv - directed self-checking bench for lcd_byte_queue
module tb_lcd_byte_queue;
  import lcd_pkg::*;

  localparam int DL = 4;
  localparam int FW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_byte_queue_if #(.DEPTH_LOG2(DL), .FILL_W(FW)) bus ();

  lcd_byte_queue #(.DEPTH_LOG2(DL), .FILL_W(FW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic m_avail = 1'b0, m_busy = 1'b0, t_avail = 1'b0, master_en = 1'b0;
  assign bus.avail = m_avail | t_avail;
  assign bus.busy  = m_busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] cap[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SPI master model: avail every 20 cycles while spistart, busy for 16 cycles after each avail
  initial begin
    int gap = 0;
    int bcnt = 0;
    forever begin
      @(negedge clk);
      m_avail = 1'b0;
      if (bcnt > 0) bcnt--;
      m_busy = (bcnt > 0);
      if (gap > 0) gap--;
      if (master_en && gap == 0 && bus.spistart === 1'b1) begin
        m_avail = 1'b1;
        cap.push_back({bus.comm, bus.message});
        bcnt = 16;
        m_busy = 1'b1;
        gap = 20;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic dc, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_dc = dc;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_cap(input int n, input int budget, input string tag);
    int c = 0;
    while (cap.size() < n && c < budget) begin
      tick();
      c++;
    end
    check_val(tag, 32'(cap.size() >= n), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while (bus.idle !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    check_val(tag, 32'(bus.idle), 1);
  endtask

  task automatic check_reset_outputs(input string p);
    check_val({p, "_message"}, 32'(bus.message), 0);
    check_val({p, "_comm"}, 32'(bus.comm), 0);
    check_val({p, "_spistart"}, 32'(bus.spistart), 0);
    check_val({p, "_full"}, 32'(bus.full), 0);
    check_val({p, "_level"}, 32'(bus.level), 0);
    check_val({p, "_overflow"}, 32'(bus.overflow), 0);
    check_val({p, "_fill_busy"}, 32'(bus.fill_busy), 0);
    check_val({p, "_idle"}, 32'(bus.idle), 1);
  endtask

  initial begin
    logic [8:0] exp2 [5];
    int max_lvl, prev_total, c, bad, viol;

    bus.wr_en = 0; bus.wr_dc = 0; bus.wr_data = 0;
    bus.fill_start = 0; bus.fill_dc = 0; bus.fill_data = 0; bus.fill_len = 0;

    // power-on reset
    repeat (3) tick();
    check_reset_outputs("por");
    rst_n = 1'b1;
    tick();

    // init sequence through the master model
    master_en = 1'b1;
    cap.delete();
    push(DC_CMD, FUNC_EXT);
    push(DC_CMD, VOP);
    push(DC_CMD, FUNC_BASIC);
    push(DC_CMD, DISP_NORMAL);
    push(DC_DATA, 8'h00);
    wait_cap(5, 300, "t2_cap_timeout");
    check_val("t2_spistart_drop", 32'(bus.spistart), 0);
    check_val("t2_not_idle_while_busy", 32'(bus.idle), 0);
    c = 0;
    while (bus.busy === 1'b1 && c < 40) begin tick(); c++; end
    check_val("t2_idle_after_busy", 32'(bus.idle), 1);
    exp2[0] = 9'h021; exp2[1] = 9'h090; exp2[2] = 9'h020; exp2[3] = 9'h00C; exp2[4] = 9'h100;
    check_val("t2_count", 32'(cap.size()), 5);
    for (int i = 0; i < 5; i++) check_val($sformatf("t2_byte%0d", i), 32'(cap[i]), 32'(exp2[i]));

    // screen clear through the fill engine
    cap.delete();
    bus.fill_dc = 1'b1; bus.fill_data = 8'h00; bus.fill_len = 10'(SCREEN_BYTES);
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
    max_lvl = 0; prev_total = 0; c = 0;
    while (c < 12000) begin
      tick();
      c++;
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
      if (c == 50) begin bus.wr_en = 1'b1; bus.wr_dc = 1'b0; bus.wr_data = 8'hAA; end
      if (c == 51) bus.wr_en = 1'b0;
      if (bus.fill_busy !== 1'b1) break;
      prev_total = cap.size() + int'(bus.level);
    end
    check_val("t3_fill_done", 32'(bus.fill_busy), 0);
    check_val("t3_written_before_last", 32'(prev_total), 503);
    check_val("t3_written_at_done", 32'(cap.size() + int'(bus.level)), 504);
    check_val("t3_max_level", 32'(max_lvl), 16);
    check_val("t3_overflow", 32'(bus.overflow), 1);
    wait_cap(504, 500, "t3_cap_timeout");
    wait_idle(100, "t3_idle_timeout");
    check_val("t3_count", 32'(cap.size()), 504);
    bad = 0;
    foreach (cap[i]) if (cap[i] !== 9'h100) bad++;
    check_val("t3_bad_bytes", 32'(bad), 0);

    // reset in the middle of a stalled fill
    master_en = 1'b0;
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
    repeat (30) tick();
    check_val("t1_pre_fill_busy", 32'(bus.fill_busy), 1);
    check_val("t1_pre_level", 32'(bus.level), 16);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t1_rst");
    rst_n = 1'b1;
    repeat (5) tick();
    check_val("t1_post_level", 32'(bus.level), 0);
    check_val("t1_post_fill_busy", 32'(bus.fill_busy), 0);

    // stalled master, 17 pushes
    cap.delete();
    for (int i = 0; i < 17; i++) push(DC_DATA, 8'(8'h40 + i));
    tick();
    check_val("t4_level", 32'(bus.level), 16);
    check_val("t4_full", 32'(bus.full), 1);
    check_val("t4_overflow", 32'(bus.overflow), 1);
    master_en = 1'b1;
    wait_cap(16, 500, "t4_cap_timeout");
    wait_idle(100, "t4_idle_timeout");
    check_val("t4_count", 32'(cap.size()), 16);
    check_val("t4_first", 32'(cap[0]), 32'h140);
    check_val("t4_last", 32'(cap[15]), 32'h14F);

    // push during DRAIN while busy
    cap.delete();
    push(DC_CMD, SET_X);
    wait_cap(1, 100, "t5_cap_timeout");
    check_val("t5_drain_spistart", 32'(bus.spistart), 0);
    bus.wr_en = 1'b1; bus.wr_dc = DC_DATA; bus.wr_data = 8'h5A;
    tick();
    bus.wr_en = 1'b0;
    check_val("t5_level_in_drain", 32'(bus.level), 1);
    c = 0; viol = 0;
    while (bus.busy === 1'b1 && c < 40) begin
      if (bus.spistart !== 1'b0) viol++;
      tick();
      c++;
    end
    check_val("t5_spistart_while_busy", 32'(viol), 0);
    check_val("t5_busy_fell", 32'(bus.busy), 0);
    check_val("t5_idle_cycle_spistart", 32'(bus.spistart), 0);
    tick();
    check_val("t5_restream_spistart", 32'(bus.spistart), 1);
    check_val("t5_restream_message", 32'(bus.message), 32'h5A);
    check_val("t5_restream_comm", 32'(bus.comm), 1);
    wait_cap(2, 100, "t5_cap2_timeout");
    check_val("t5_cap_byte", 32'(cap[1]), 32'h15A);
    wait_idle(100, "t5_idle_timeout");

    // simultaneous push and pop at level 3
    master_en = 1'b0;
    push(DC_CMD, 8'h01);
    push(DC_CMD, 8'h02);
    push(DC_CMD, 8'h03);
    check_val("t6_level_before", 32'(bus.level), 3);
    check_val("t6_head_before", 32'(bus.message), 32'h01);
    bus.wr_en = 1'b1; bus.wr_dc = DC_CMD; bus.wr_data = 8'h04;
    t_avail = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    t_avail = 1'b0;
    check_val("t6_level_after", 32'(bus.level), 3);
    check_val("t6_head_after", 32'(bus.message), 32'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_byte_queue.md
Name: lcd_byte_queue

Overview:
- Elastic command/data queue between the display sequencer (which produces {dc, byte} pairs) and the SPI master that serialises bytes to the PCD8544 LCD.
- Decouples the sequencer from SPI byte timing.
- Includes a hardware fill engine that emits N copies of one byte (e.g. 504 × 0x00 screen clear), so the sequencer does not have to count bytes.
- Drives the master's message/comm/spistart inputs and consumes its busy/avail outputs.

Parameters:
DEPTH_LOG2, 4, queue depth = 2^DEPTH_LOG2 entries (16)
FILL_W, 10, width of fill length counter (max 1023 bytes)

Ports:
clock  in  1  system clock
Reset  in  1  asynchronous, active-low reset
wr_en  in  1  push request, one entry per cycle
wr_dc  in  1  entry type: 0 = command, 1 = data
wr_data  in  8  entry byte
fill_start  in  1  one-cycle pulse; starts fill engine
fill_dc  in  1  dc for fill bytes
fill_data  in  8  fill byte value
fill_len  in  FILL_W  number of fill bytes; 0 = no-op
full  out  1  queue cannot accept a push (also high while fill engine runs)
level  out  DEPTH_LOG2+1  entries stored
overflow  out  1  sticky: a push was dropped
fill_busy  out  1  fill engine active
idle  out  1  queue empty, fill idle, master not busy
busy  in  1  SPI master shifting a byte
avail  in  1  one-cycle pulse: master has sampled message/comm and wants the next byte
message  out  8  head byte to master
comm  out  1  head dc to master
spistart  out  1  request master to transmit

Behaviour:
- Reset values: message=0, comm=0, spistart=0, full=0, level=0, overflow=0, fill_busy=0, idle=1, state=IDLE, FIFO pointers 0, fill counter 0.
- Reset is asynchronous. It clears the queue and aborts any fill mid-operation. The in-flight SPI byte is not this block's concern.
- Push:
  - Accepted iff wr_en=1, fill_busy=0 and level<DEPTH.
  - A push with full=1 is dropped and sets overflow (sticky until Reset).
  - A push and a pop in the same cycle are both performed; level is unchanged.
  - A push while full is dropped even if a pop occurs in that cycle.
- Fill engine:
  - fill_start with fill_len≠0 and fill_busy=0 loads the counter and sets fill_busy and full.
  - Each cycle with level<DEPTH it writes {fill_dc, fill_data} and decrements the counter.
  - fill_busy clears the cycle after the last entry is written.
  - fill_start while fill_busy=1 is ignored. wr_en during fill is dropped and sets overflow.
- Output path:
  - message/comm are registered from the FIFO head.
  - Latency: a push into an empty queue in cycle N gives spistart=1 and valid message/comm in N+1.
- State machine:
  - IDLE: spistart=0. Leave to STREAM when level>0.
  - STREAM: spistart=1, message/comm = head. On avail, pop the head and present the next head the following cycle. If the pop empties the queue and no push or fill write occurs that cycle, go to DRAIN.
  - DRAIN: spistart=0; wait for busy=0, then go to IDLE. Entries pushed during DRAIN wait until IDLE, then STREAM restarts.
  - avail outside STREAM is ignored; no pop occurs.
- idle=1 iff state=IDLE, level=0, fill_busy=0 and busy=0.
- level is a DEPTH_LOG2+1-bit count; FIFO pointers wrap modulo DEPTH.

Decomposition:
- Package lcd_pkg:
  - DC_CMD=0, DC_DATA=1.
  - PCD8544 constants: FUNC_EXT=0x21, VOP=0x90, FUNC_BASIC=0x20, DISP_NORMAL=0x0C, SET_X=0x80, SET_Y=0x40, SCREEN_BYTES=504.
  - Queue state encodings IDLE/STREAM/DRAIN.
- One sub-module, lcd_sync_fifo: 9-bit wide, depth 2^DEPTH_LOG2, with push/pop, level and full/empty.
- Fill engine and state machine live in lcd_byte_queue.

Test Plan:
1. Reset low mid-test → next cycle all outputs at reset values, level=0, spistart=0, idle=1.
2. Stimulus:
   - Push cmd 0x21, 0x90, 0x20, 0x0C, then data 0x00.
   - Master model pulses avail every 20 cycles, busy=1 for 16 cycles after each avail.

   Required response:
   - message/comm sequence is 21/0, 90/0, 20/0, 0C/0, 00/1.
   - spistart drops the cycle after the 5th avail.
   - idle=1 once busy falls.
3. fill_start, fill_len=504, fill_data=0x00, fill_dc=1 → exactly 504 avail-consumed bytes, all 00/1; level never exceeds 16; fill_busy low after the 504th write; wr_en during fill sets overflow.
4. Master stalled (no avail), 17 pushes → level=16, full=1, overflow=1; 17th entry never transmitted.
5. Push one byte while in DRAIN with busy=1 → spistart stays 0 until busy=0; STREAM resumes with that byte one cycle after IDLE.
6. Push and avail in the same cycle with level=3 → level stays 3; next message = second entry.
